// File: rtl/va_ovc_state.sv
// Output-VC stage of the VC allocator: per-VC round-robin grant, credit counting and release.
// Optional feature macro VA_ATOMIC_VC_EN: hold a VC in DRAIN after its tail until every credit is back.
module va_ovc_state #(
  parameter  int unsigned N         = 5,
  parameter  int unsigned V         = 4,
  parameter  int unsigned BUF_DEPTH = 4,
  localparam int unsigned R         = N * V,
  localparam int unsigned IW        = $clog2(R),
  localparam int unsigned VW        = $clog2(V),
  localparam int unsigned CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R*V-1:0]  req_in,
  output logic [R*V-1:0]  grant_out,
  output logic [V-1:0]    out_vc_available,
  output logic [V*IW-1:0] owner_out,
  input  logic            flit_sent_valid,
  input  logic [VW-1:0]   flit_sent_vc,
  input  logic            flit_sent_tail,
  input  logic            credit_valid,
  input  logic [VW-1:0]   credit_vc,
  output logic [V-1:0]    has_credit,
  output logic            err
);

  localparam int unsigned SW = IW + 1;

`ifdef VA_ATOMIC_VC_EN
  localparam bit ATOMIC = 1'b1;
`else
  localparam bit ATOMIC = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t          r_state [V];
  logic [CW-1:0]   r_cnt   [V];
  logic [IW-1:0]   r_owner [V];
  logic [IW-1:0]   r_ptr   [V];
  logic            r_err;

  logic [V-1:0]    w_flit;
  logic [V-1:0]    w_cred;
  logic [CW-1:0]   w_cnt_nxt [V];
  logic [V-1:0]    w_err_vc;
  logic [R-1:0]    w_reqv    [V];
  logic [R-1:0]    w_onehot  [V];
  logic [V-1:0]    w_found;
  logic [IW-1:0]   w_win     [V];
  logic [SW-1:0]   w_sum;
  logic [R*V-1:0]  w_grant_nxt;

  // Decode the per-VC flit and credit events
  always_comb begin
    w_flit = '0;
    w_cred = '0;
    for (int unsigned o = 0; o < V; o++) begin
      w_flit[o] = flit_sent_valid && (flit_sent_vc == VW'(o));
      w_cred[o] = credit_valid && (credit_vc == VW'(o));
    end
  end

  // Next credit count; overflow/underflow saturate and flag an error
  always_comb begin
    w_err_vc = '0;
    for (int unsigned o = 0; o < V; o++) begin
      w_cnt_nxt[o] = r_cnt[o];
      if (w_flit[o] && !w_cred[o]) begin
        if (r_cnt[o] == '0) w_err_vc[o] = 1'b1;
        else                w_cnt_nxt[o] = r_cnt[o] - CW'(1);
      end else if (w_cred[o] && !w_flit[o]) begin
        if (r_cnt[o] == CW'(BUF_DEPTH)) w_err_vc[o] = 1'b1;
        else                            w_cnt_nxt[o] = r_cnt[o] + CW'(1);
      end
      if (w_flit[o] && (r_state[o] == S_IDLE)) w_err_vc[o] = 1'b1;
    end
  end

  // Regroup requests per output VC
  always_comb begin
    for (int unsigned o = 0; o < V; o++) begin
      w_reqv[o] = '0;
      for (int unsigned k = 0; k < R; k++) w_reqv[o][k] = req_in[k*V+o];
    end
  end

  // Round-robin: first requester at or after the pointer, wrapping at R
  always_comb begin
    w_sum   = '0;
    w_found = '0;
    for (int unsigned o = 0; o < V; o++) begin
      w_win[o]    = '0;
      w_onehot[o] = '0;
      for (int unsigned i = 0; i < R; i++) begin
        w_sum = {1'b0, r_ptr[o]} + SW'(i);
        if (w_sum >= SW'(R)) w_sum = w_sum - SW'(R);
        if (!w_found[o] && w_reqv[o][w_sum[IW-1:0]]) begin
          w_found[o] = 1'b1;
          w_win[o]   = w_sum[IW-1:0];
        end
      end
      if (w_found[o]) w_onehot[o][w_win[o]] = 1'b1;
    end
  end

  always_comb begin
    w_grant_nxt = '0;
    for (int unsigned o = 0; o < V; o++) begin
      for (int unsigned k = 0; k < R; k++) begin
        w_grant_nxt[k*V+o] = w_onehot[o][k] && (r_state[o] == S_IDLE);
      end
    end
  end

  always_comb begin
    owner_out        = '0;
    out_vc_available = '0;
    has_credit       = '0;
    for (int unsigned o = 0; o < V; o++) begin
      owner_out[o*IW +: IW] = r_owner[o];
      out_vc_available[o]   = (r_state[o] == S_IDLE);
      has_credit[o]         = (r_cnt[o] != '0);
    end
  end

  assign err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned o = 0; o < V; o++) begin
        r_state[o] <= S_IDLE;
        r_cnt[o]   <= CW'(BUF_DEPTH);
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
      grant_out <= '0;
      r_err     <= 1'b0;
    end else begin
      grant_out <= w_grant_nxt;
      if (|w_err_vc) r_err <= 1'b1;
      for (int unsigned o = 0; o < V; o++) begin
        r_cnt[o] <= w_cnt_nxt[o];
        case (r_state[o])
          S_IDLE: begin
            if (w_found[o]) begin
              r_state[o] <= S_ACTIVE;
              r_owner[o] <= w_win[o];
              r_ptr[o]   <= (w_win[o] == IW'(R - 1)) ? '0 : w_win[o] + IW'(1);
            end
          end
          S_ACTIVE: begin
            if (w_flit[o] && flit_sent_tail) r_state[o] <= ATOMIC ? S_DRAIN : S_IDLE;
          end
          S_DRAIN: begin
            if (w_cnt_nxt[o] == CW'(BUF_DEPTH)) r_state[o] <= S_IDLE;
          end
          default: r_state[o] <= S_IDLE;
        endcase
      end
    end
  end

endmodule
